// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding load/store, programmable wait states,
// misaligned or out-of-range accesses answered with an error and no memory side effect.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam bit          NoWait   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [Depth];

  logic              accept;
  logic              use_req;
  logic              wait_done;
  logic              do_access;
  logic              mem_we;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_err;

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign accept    = req_valid_i && (state_q == StIdle);
  assign wait_done = (cnt_q <= 4'd1);

  // With no wait states the access happens on the accept edge, straight from the request bus.
  assign use_req   = (state_q == StIdle);
  assign acc_we    = use_req ? req_we_i    : we_q;
  assign acc_addr  = use_req ? req_addr_i  : addr_q;
  assign acc_wdata = use_req ? req_wdata_i : wdata_q;
  assign acc_be    = use_req ? req_be_i    : be_q;
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);

  // Gated by reset so nothing is written while reset is held low.
  assign do_access = rst_ni && ((accept && NoWait) || ((state_q == StWait) && wait_done));
  assign mem_we    = do_access && acc_we && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if (NoWait) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (wait_done) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? '0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset: contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance A (one wait state) under directed and random traffic against a
// word-array model; instance B (three wait states) for latency and reset-abort behaviour.
module tb_dmem_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned WA = 1;
  localparam int unsigned WB = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Instance A signals
  logic        a_rst_n = 1'b0;
  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_be = '0;
  logic        a_rsp_ready = 1'b0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  // Instance B signals
  logic        b_rst_n = 1'b0;
  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_rsp_ready = 1'b1;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WA)) u_dut_a (
    .clk_i       (clk_i),
    .rst_ni      (a_rst_n),
    .req_valid_i (a_req_valid),
    .req_ready_o (a_req_ready),
    .req_we_i    (a_req_we),
    .req_addr_i  (a_req_addr),
    .req_wdata_i (a_req_wdata),
    .req_be_i    (a_req_be),
    .rsp_valid_o (a_rsp_valid),
    .rsp_ready_i (a_rsp_ready),
    .rsp_rdata_o (a_rsp_rdata),
    .rsp_err_o   (a_rsp_err)
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WB)) u_dut_b (
    .clk_i       (clk_i),
    .rst_ni      (b_rst_n),
    .req_valid_i (b_req_valid),
    .req_ready_o (b_req_ready),
    .req_we_i    (b_req_we),
    .req_addr_i  (b_req_addr),
    .req_wdata_i (b_req_wdata),
    .req_be_i    (b_req_be),
    .rsp_valid_o (b_rsp_valid),
    .rsp_ready_i (b_rsp_ready),
    .rsp_rdata_o (b_rsp_rdata),
    .rsp_err_o   (b_rsp_err)
  );

  // Reference model: plain word array, updated in issue order.
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic [31:0] mdl [2**AW];
  exp_t        exp_q [$];
  int          acc_q [$];

  function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int unsigned idx;
    e.err   = (addr % 4 != 0) || (addr >= (32'd4 << AW));
    e.rdata = '0;
    idx     = (addr / 4) % (2 ** AW);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        e.rdata = mdl[idx];
      end
    end
    return e;
  endfunction

  // rsp_ready for A: 0 = random, 1 = always ready, 2 = held low
  int ready_mode = 1;
  always @(posedge clk_i) begin
    #1;
    if (ready_mode == 0) a_rsp_ready = 1'($urandom_range(0, 1));
    else a_rsp_ready = (ready_mode == 1);
  end

  // Monitor for A
  logic        prev_valid = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err = 1'b0;
  logic        hs_pending = 1'b0;
  always @(negedge clk_i) begin
    int   acc;
    exp_t e;
    if (!a_rst_n) begin
      prev_valid = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending) begin
        check("a_rsp_done_valid", a_rsp_valid, 0);
        check("a_ready_after_rsp", a_req_ready, 1);
        hs_pending = 1'b0;
      end
      if (a_rsp_valid) begin
        check("a_ready_in_resp", a_req_ready, 0);
        if (!prev_valid) begin
          if (acc_q.size() == 0) begin
            check("a_unexpected_rsp", 0, 1);
          end else begin
            acc = acc_q.pop_front();
            // Edges from accept to the first edge that samples rsp_valid high.
            check("a_latency", cyc + 1 - acc, 1 + WA);
          end
        end else begin
          check("a_hold_rdata", a_rsp_rdata, prev_rdata);
          check("a_hold_err", a_rsp_err, prev_err);
        end
        if (a_rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("a_no_expected", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("a_rdata", a_rsp_rdata, e.rdata);
            check("a_err", a_rsp_err, e.err);
          end
          hs_pending = 1'b1;
        end
      end
      prev_valid = a_rsp_valid;
      prev_rdata = a_rsp_rdata;
      prev_err   = a_rsp_err;
    end
  end

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    int n = 0;
    @(negedge clk_i);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    while (!a_req_ready && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!a_req_ready) begin
      check("a_accept_timeout", 0, 1);
      a_req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_access(we, addr, wdata, be));
    acc_q.push_back(cyc + 1);
    @(posedge clk_i);
    #1;
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom);
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    a_req_be    = 4'($urandom);
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!a_rsp_valid && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!a_rsp_valid) check("a_valid_timeout", 0, 1);
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("a_drain", exp_q.size(), 0);
    @(negedge clk_i);
  endtask

  task automatic b_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    @(negedge clk_i);
    check({tag, "_ready"}, b_req_ready, 1);
    b_req_valid = 1'b1;
    b_req_we    = we;
    b_req_addr  = addr;
    b_req_wdata = wdata;
    b_req_be    = be;
    @(posedge clk_i);
    #1;
    b_req_valid = 1'b0;
    b_req_we    = 1'($urandom);
    b_req_addr  = $urandom;
    b_req_wdata = $urandom;
    b_req_be    = 4'($urandom);
    while (!b_rsp_valid && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check({tag, "_latency"}, n + 1, 1 + WB);
    check({tag, "_rdata"}, b_rsp_rdata, exp_rdata);
    check({tag, "_err"}, b_rsp_err, exp_err);
    @(posedge clk_i);
    #1;
    check({tag, "_done"}, b_rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        we;
    logic [31:0] addr;

    #1;
    check("a_rst_req_ready", a_req_ready, 1);
    check("a_rst_rsp_valid", a_rsp_valid, 0);
    check("a_rst_rdata", a_rsp_rdata, 0);
    check("a_rst_err", a_rsp_err, 0);
    check("b_rst_req_ready", b_req_ready, 1);
    check("b_rst_rsp_valid", b_rsp_valid, 0);
    repeat (2) @(negedge clk_i);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    for (int w = 0; w < 16; w++) issue_a(1'b1, 32'(w * 4), $urandom, 4'hF);

    issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    issue_a(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    issue_a(1'b0, 32'h13, $urandom, 4'($urandom));
    issue_a(1'b0, 32'h0000_1000, $urandom, 4'($urandom));
    issue_a(1'b1, 32'h13, 32'hFFFF_FFFF, 4'hF);
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    issue_a(1'b1, 32'h10, 32'h1111_1111, 4'h0);
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    drain_a();

    // Back-pressure: response must hold while rsp_ready stays low.
    ready_mode = 2;
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    wait_valid_a();
    repeat (5) @(negedge clk_i);
    ready_mode = 1;
    drain_a();

    ready_mode = 0;
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom);
      addr = 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 7))
        0: addr = addr + 32'($urandom_range(1, 3));
        1: addr = addr | (32'h1 << $urandom_range(AW + 2, 31));
        default: ;
      endcase
      issue_a(we, addr, $urandom, 4'($urandom));
    end
    ready_mode = 1;
    drain_a();

    // Asynchronous reset while a response is pending drops it.
    ready_mode = 2;
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    wait_valid_a();
    @(negedge clk_i);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("a_pulse_req_ready", a_req_ready, 1);
    check("a_pulse_rsp_valid", a_rsp_valid, 0);
    check("a_pulse_rdata", a_rsp_rdata, 0);
    check("a_pulse_err", a_rsp_err, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk_i);
    a_rst_n = 1'b1;
    repeat (3) @(negedge clk_i);
    check("a_dropped_rsp", a_rsp_valid, 0);
    ready_mode = 1;
    issue_a(1'b0, 32'h10, $urandom, 4'($urandom));
    drain_a();

    // Instance B: three wait states, reset during WAIT aborts the store.
    b_txn("b_st0", 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    b_txn("b_ld0", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk_i);
    b_req_valid = 1'b1;
    b_req_we    = 1'b1;
    b_req_addr  = 32'h20;
    b_req_wdata = 32'h1234_5678;
    b_req_be    = 4'hF;
    @(posedge clk_i);
    #1;
    b_req_valid = 1'b0;
    @(posedge clk_i);
    #3;
    check("b_in_wait_ready", b_req_ready, 0);
    check("b_in_wait_valid", b_rsp_valid, 0);
    b_rst_n = 1'b0;
    #1;
    check("b_abort_req_ready", b_req_ready, 1);
    check("b_abort_rsp_valid", b_rsp_valid, 0);
    check("b_abort_rdata", b_rsp_rdata, 0);
    check("b_abort_err", b_rsp_err, 0);
    repeat (2) @(negedge clk_i);
    b_rst_n = 1'b1;
    repeat (4) @(negedge clk_i);
    check("b_idle_after_abort", b_rsp_valid, 0);
    b_txn("b_ld1", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning wait states between request accept and the memory access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
REQ-005 req_valid  input  1  CPU load/store request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i enables byte lane [8i+7:8i].
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  CPU accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; exactly one request outstanding at a time.
REQ-016 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready at a posedge.
REQ-017 On accept, latch we/addr/wdata/be; go to WAIT and load the wait counter with WAIT_CYCLES; if WAIT_CYCLES==0, perform the access on the accept edge and go directly to RESP.
REQ-018 In WAIT, decrement the counter each cycle; on the edge where the counter equals 1, perform the access and go to RESP.
REQ-019 Latency: rsp_valid SHALL first be 1 exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-020 Access: a load captures mem[addr[ADDR_W+1:2]] into rsp_rdata; a store writes only the enabled byte lanes and sets rsp_rdata=0.
REQ-021 Error: if addr[1:0]!=0, or addr[31:ADDR_W+2]!=0, then rsp_err=1, rsp_rdata=0, and memory is unmodified; otherwise rsp_err=0.
REQ-022 A store with req_be==0 completes normally with rsp_err=0 and leaves memory unchanged.
REQ-023 In RESP, rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_valid & rsp_ready; on that edge, return to IDLE.
REQ-024 No new request is accepted on the same edge that a response completes; req_ready rises in the following cycle.
REQ-025 req_* inputs are ignored outside IDLE; changes to them after accept do not affect the latched request.
REQ-026 Load-after-store to the same address SHALL return the newly stored data.

Reset
REQ-027 While reset==0: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all latches cleared.
REQ-028 Memory array contents are not cleared by reset.
REQ-029 Reset asserted in WAIT before the access edge aborts the request with no memory write; reset asserted in RESP drops the response.

Verification
REQ-030 Reset pulse -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately (asynchronously).
REQ-031 WAIT_CYCLES=1: store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid 2 cycles after each accept.
REQ-032 Then store 0x0000AB00 to 0x10 with be=4'b0010, and load -> 0xDEADABEF.
REQ-033 Load 0x13, and load 0x00001000 with ADDR_W=10 -> rsp_err=1 and rsp_rdata=0 for both; a store to 0x13 leaves memory unchanged on re-read.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, and rsp_err stay stable and req_ready=0 throughout; the response completes on the first rsp_ready=1 edge.
REQ-035 Store 0x12345678 to 0x20 with WAIT_CYCLES=3 and assert reset during WAIT -> FSM returns to IDLE and a subsequent load of 0x20 returns the prior contents.
